// File: rtl/io_port_bank.sv
// Memory-mapped I/O port bank: CH registered output channels, CH synchronised input channels, sticky change flags.
// Define IO_DEBOUNCE_EN to add per-channel debounce counters of DEB_CYCLES cycles.
module io_port_bank #(
  parameter int          CH         = 3,
  parameter int          DW         = 8,
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FC60,
  parameter int          DEB_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_read,
  input  logic             io_write,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [CH*DW-1:0] in_pins,
  output logic [CH*DW-1:0] out_pins,
  output logic [CH-1:0]    chg_flag
);

  logic [31:0]   offset;
  logic [29:0]   word_idx;
  logic          stat_hit;
  logic [CH-1:0] chan_dec;
  logic [DW-1:0] stable_w [CH];

  // addr[1:0] is dropped by taking the word index of the wrapped offset
  assign offset   = addr - BASE_ADDR;
  assign word_idx = offset[31:2];
  assign stat_hit = (word_idx == 30'(CH));

  logic unused_bits;
  assign unused_bits = ^{wdata, offset[1:0]};

  for (genvar k = 0; k < CH; k++) begin : g_ch
    logic [DW-1:0] out_q;
    logic [DW-1:0] sync1_q;
    logic [DW-1:0] sync2_q;
    logic [DW-1:0] stable_q;
    logic          flag_q;
    logic          upd;
    logic          flag_clr;

    assign chan_dec[k] = (word_idx == 30'(k));

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        out_q <= '0;
      end else if (io_write && chan_dec[k]) begin
        out_q <= wdata[DW-1:0];
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        sync1_q  <= '0;
        sync2_q  <= '0;
        stable_q <= '0;
      end else begin
        sync1_q <= in_pins[k*DW +: DW];
        sync2_q <= sync1_q;
        if (upd) stable_q <= sync2_q;
      end
    end

`ifdef IO_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES) + 1;
    logic [CW-1:0] cnt_q;

    assign upd = (sync2_q != stable_q) && (cnt_q == CW'(DEB_CYCLES - 1));

    // any return to the stable value restarts qualification from zero
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
      end else if (upd || (sync2_q == stable_q)) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
`else
    localparam int unused_deb = DEB_CYCLES;
    assign upd = (sync2_q != stable_q);
`endif

    assign flag_clr = (io_read && chan_dec[k]) || (io_write && stat_hit && wdata[k]);

    // a qualifying change on the same edge as a clear keeps the flag set
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        flag_q <= 1'b0;
      end else if (upd) begin
        flag_q <= 1'b1;
      end else if (flag_clr) begin
        flag_q <= 1'b0;
      end
    end

    assign out_pins[k*DW +: DW] = out_q;
    assign stable_w[k]          = stable_q;
    assign chg_flag[k]          = flag_q;
  end

  always_comb begin
    rdata = '0;
    if (io_read) begin
      if (stat_hit) rdata[CH-1:0] = chg_flag;
      for (int k = 0; k < CH; k++) begin
        if (chan_dec[k]) rdata[DW-1:0] = stable_w[k];
      end
    end
  end

endmodule
